// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the registered immediate generator: format codes,
// instruction width and the 32-bit immediate extraction helper.
package imm_gen_pipe_pkg;

   localparam int WORDSIZE = 32;

   localparam logic [2:0] IMM_R   = 3'd0;
   localparam logic [2:0] IMM_I   = 3'd1;
   localparam logic [2:0] IMM_S   = 3'd2;
   localparam logic [2:0] IMM_B   = 3'd3;
   localparam logic [2:0] IMM_U   = 3'd4;
   localparam logic [2:0] IMM_J   = 3'd5;
   localparam logic [2:0] IMM_Z   = 3'd6;
   localparam logic [2:0] IMM_RSV = 3'd7;

   // Immediate as a 32-bit value; bit 31 is the sign to replicate for wider XLEN.
   // R, Z and the reserved code all leave bit 31 clear.
   function automatic logic [WORDSIZE-1:0] base_imm(input logic [WORDSIZE-1:0] instr,
                                                    input logic [2:0]          fmt);
      logic [WORDSIZE-1:0] imm;
      case (fmt)
         IMM_R:   imm = 32'd0;
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'd0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_Z:   imm = {27'd0, instr[19:15]};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational immediate extraction and sign extension up to XLEN.
module imm_extract
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [WORDSIZE-1:0] instr,
   input  logic [2:0]          fmt,
   output logic [XLEN-1:0]     imm,
   output logic                illegal
);

   logic [WORDSIZE-1:0] imm32_s;
   logic                unused_opcode_s;

   if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
      $error("imm_extract: XLEN must be 32 or 64");
   end

   // Format-dependent 32-bit immediate; the opcode bits never contribute.
   always_comb begin
      imm32_s = base_imm(instr, fmt);
   end

   assign unused_opcode_s = ^instr[6:0];

   if (XLEN == 32) begin : g_x32
      assign imm = imm32_s;
   end else begin : g_wide
      assign imm = {{(XLEN-32){imm32_s[31]}}, imm32_s};
   end

   assign illegal = (fmt == IMM_RSV);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a two-entry
// (main + skid) buffer so downstream stalls never drop or reorder items.
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORDSIZE-1:0] in_instr,
   input  logic [2:0]          in_fmt,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_imm,
   output logic [2:0]          out_fmt,
   output logic                out_illegal
);

   logic [XLEN-1:0] ext_imm_s;
   logic            ext_ill_s;

   logic            main_valid_r, main_valid_s;
   logic [XLEN-1:0] main_imm_r,   main_imm_s;
   logic [2:0]      main_fmt_r,   main_fmt_s;
   logic            main_ill_r,   main_ill_s;
   logic            skid_valid_r, skid_valid_s;
   logic [XLEN-1:0] skid_imm_r,   skid_imm_s;
   logic [2:0]      skid_fmt_r,   skid_fmt_s;
   logic            skid_ill_r,   skid_ill_s;
   logic            in_ready_r,   in_ready_s;

   logic            accept_s;
   logic            main_free_s;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (in_instr),
      .fmt     (in_fmt),
      .imm     (ext_imm_s),
      .illegal (ext_ill_s)
   );

   // Next state of both entries: main refills from skid first, then from the input.
   always_comb begin
      accept_s     = in_valid & in_ready_r;
      main_free_s  = ~main_valid_r | out_ready;
      main_valid_s = main_valid_r;
      main_imm_s   = main_imm_r;
      main_fmt_s   = main_fmt_r;
      main_ill_s   = main_ill_r;
      skid_valid_s = skid_valid_r;
      skid_imm_s   = skid_imm_r;
      skid_fmt_s   = skid_fmt_r;
      skid_ill_s   = skid_ill_r;
      in_ready_s   = in_ready_r;
      if (flush) begin
         // Flush wins over a same-cycle accept.
         main_valid_s = 1'b0;
         main_imm_s   = '0;
         main_fmt_s   = IMM_R;
         main_ill_s   = 1'b0;
         skid_valid_s = 1'b0;
         skid_imm_s   = '0;
         skid_fmt_s   = IMM_R;
         skid_ill_s   = 1'b0;
         in_ready_s   = 1'b1;
      end else begin
         if (main_free_s) begin
            if (skid_valid_r) begin
               main_valid_s = 1'b1;
               main_imm_s   = skid_imm_r;
               main_fmt_s   = skid_fmt_r;
               main_ill_s   = skid_ill_r;
               skid_valid_s = accept_s;
               skid_imm_s   = ext_imm_s;
               skid_fmt_s   = in_fmt;
               skid_ill_s   = ext_ill_s;
            end else if (accept_s) begin
               main_valid_s = 1'b1;
               main_imm_s   = ext_imm_s;
               main_fmt_s   = in_fmt;
               main_ill_s   = ext_ill_s;
            end else begin
               main_valid_s = 1'b0;
            end
         end else begin
            if (accept_s && !skid_valid_r) begin
               skid_valid_s = 1'b1;
               skid_imm_s   = ext_imm_s;
               skid_fmt_s   = in_fmt;
               skid_ill_s   = ext_ill_s;
            end else begin
               skid_valid_s = skid_valid_r;
            end
         end
         in_ready_s = ~skid_valid_s;
      end
   end

   // Entry and ready registers; reset clears content and holds off input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_r <= 1'b0;
         main_imm_r   <= '0;
         main_fmt_r   <= IMM_R;
         main_ill_r   <= 1'b0;
         skid_valid_r <= 1'b0;
         skid_imm_r   <= '0;
         skid_fmt_r   <= IMM_R;
         skid_ill_r   <= 1'b0;
         in_ready_r   <= 1'b0;
      end else begin
         main_valid_r <= main_valid_s;
         main_imm_r   <= main_imm_s;
         main_fmt_r   <= main_fmt_s;
         main_ill_r   <= main_ill_s;
         skid_valid_r <= skid_valid_s;
         skid_imm_r   <= skid_imm_s;
         skid_fmt_r   <= skid_fmt_s;
         skid_ill_r   <= skid_ill_s;
         in_ready_r   <= in_ready_s;
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = main_valid_r;
   assign out_imm     = main_imm_r;
   assign out_fmt     = main_fmt_r;
   assign out_illegal = main_ill_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance
// share all inputs; each has its own expected-output queue.
module tb_imm_gen_pipe;
   import imm_gen_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = 32'd0;
   logic [2:0]  in_fmt = 3'd0;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_imm32;
   logic [2:0]  out_fmt32;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt64;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      int          acc;
      bit          lat1;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   exp_t me;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   imm_gen_pipe #(.XLEN(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid32), .out_ready(out_ready),
      .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32));

   imm_gen_pipe #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64));

   always #5 clk = ~clk;

   // Cycle counter used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples 1 time unit before each rising edge and pops on every transfer.
   always begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1 && out_ready === 1'b1) begin
         if (out_valid32 === 1'b1) begin
            if (q32.size() == 0) begin
               checks++; errors++;
               $display("FAIL out32_unexpected: got imm %h expected no output", out_imm32);
            end else begin
               me = q32.pop_front();
               check("imm32", {32'd0, out_imm32}, me.imm);
               check("fmt32", {61'd0, out_fmt32}, {61'd0, me.fmt});
               check("ill32", {63'd0, out_illegal32}, {63'd0, me.ill});
               if (me.lat1) check("lat32", 64'(cyc - me.acc), 64'd1);
            end
         end
         if (out_valid64 === 1'b1) begin
            if (q64.size() == 0) begin
               checks++; errors++;
               $display("FAIL out64_unexpected: got imm %h expected no output", out_imm64);
            end else begin
               me = q64.pop_front();
               check("imm64", out_imm64, me.imm);
               check("fmt64", {61'd0, out_fmt64}, {61'd0, me.fmt});
               check("ill64", {63'd0, out_illegal64}, {63'd0, me.ill});
               if (me.lat1) check("lat64", 64'(cyc - me.acc), 64'd1);
            end
         end
      end
   end

   // Called just after a falling edge; returns just after the edge following acceptance.
   task automatic send(input logic [31:0] instr, input logic [2:0] fmt, input logic [31:0] e32,
                       input logic [63:0] e64, input logic ill, input bit lat1, input bit must_rdy);
      int   n;
      exp_t e;
      n = 0;
      if (must_rdy) check("stream_in_ready", {63'd0, in_ready64}, 64'd1);
      while (in_ready64 !== 1'b1 && n < 50) begin
         in_valid = 1'b0;
         @(negedge clk);
         n++;
      end
      if (in_ready64 !== 1'b1) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready %b after %0d cycles, expected 1", in_ready64, n);
         in_valid = 1'b0;
      end else begin
         in_valid = 1'b1;
         in_instr = instr;
         in_fmt   = fmt;
         e.fmt = fmt; e.ill = ill; e.acc = cyc; e.lat1 = lat1;
         e.imm = {32'd0, e32};
         q32.push_back(e);
         e.imm = e64;
         q64.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int          n;
      logic [11:0] v;
      logic [31:0] w;
      // Reset state
      #1;
      check("rst_out_valid", {63'd0, out_valid64}, 64'd0);
      check("rst_out_imm", out_imm64, 64'd0);
      check("rst_out_fmt", {61'd0, out_fmt64}, {61'd0, IMM_R});
      check("rst_out_illegal", {63'd0, out_illegal32}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready32}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_release", {63'd0, in_ready64}, 64'd1);

      // Extraction, one cycle latency, out_ready held high
      out_ready = 1'b1;
      send(32'hFFF00093, IMM_I, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0);
      send(32'hFE20AE23, IMM_S, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b1, 1'b0);
      send(32'h00000463, IMM_B, 32'h00000008, 64'h0000000000000008, 1'b0, 1'b1, 1'b0);
      send(32'hFE000FE3, IMM_B, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1, 1'b0);
      send(32'h123450B7, IMM_U, 32'h12345000, 64'h0000000012345000, 1'b0, 1'b1, 1'b0);
      send(32'h800000B7, IMM_U, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b1, 1'b0);
      send(32'hFFFFF06F, IMM_J, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1, 1'b0);
      send(32'h0080006F, IMM_J, 32'h00000008, 64'h0000000000000008, 1'b0, 1'b1, 1'b0);
      send(32'h000FD073, IMM_Z, 32'h0000001F, 64'h000000000000001F, 1'b0, 1'b1, 1'b0);
      send(32'hFFFFFFFF, IMM_RSV, 32'h00000000, 64'h0, 1'b1, 1'b1, 1'b0);
      send(32'hFFFFFFFF, IMM_R, 32'h00000000, 64'h0, 1'b0, 1'b1, 1'b0);
      send(32'h00500093, IMM_I, 32'h00000005, 64'h5, 1'b0, 1'b1, 1'b0);
      idle(3);

      // Backpressure: A and B accepted, C held off until the stall clears
      out_ready = 1'b0;
      send(32'h00A00093, IMM_I, 32'h0000000A, 64'hA, 1'b0, 1'b0, 1'b0);
      send(32'h00B00093, IMM_I, 32'h0000000B, 64'hB, 1'b0, 1'b0, 1'b0);
      check("bp_in_ready_low", {63'd0, in_ready64}, 64'd0);
      in_valid = 1'b1;
      in_instr = 32'h00C00093;
      in_fmt   = IMM_I;
      @(negedge clk);
      check("bp_in_ready_still_low", {63'd0, in_ready32}, 64'd0);
      check("bp_out_hold", out_imm64, 64'hA);
      out_ready = 1'b1;
      send(32'h00C00093, IMM_I, 32'h0000000C, 64'hC, 1'b0, 1'b0, 1'b0);
      idle(4);

      // Streaming: 16 items back-to-back, in_ready must never drop
      for (int i = 0; i < 16; i++) begin
         v = 12'(i * 291);
         w = {v, 20'h00093};
         send(w, IMM_I, {{20{v[11]}}, v}, {{52{v[11]}}, v}, 1'b0, 1'b1, 1'b1);
      end
      idle(3);

      // Flush with both entries full and a same-cycle input
      out_ready = 1'b0;
      send(32'h00100093, IMM_I, 32'h1, 64'h1, 1'b0, 1'b0, 1'b0);
      send(32'h00200093, IMM_I, 32'h2, 64'h2, 1'b0, 1'b0, 1'b0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h00300093;
      in_fmt   = IMM_I;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", {63'd0, out_valid64}, 64'd0);
      check("flush_in_ready", {63'd0, in_ready64}, 64'd1);
      q32.delete();
      q64.delete();
      out_ready = 1'b1;
      idle(4);

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      send(32'hFFFFF06F, IMM_J, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {63'd0, out_valid64}, 64'd0);
      check("arst_out_imm", out_imm64, 64'd0);
      check("arst_out_fmt", {61'd0, out_fmt32}, {61'd0, IMM_R});
      check("arst_in_ready", {63'd0, in_ready64}, 64'd0);
      q32.delete();
      q64.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_in_ready_release", {63'd0, in_ready64}, 64'd1);
      out_ready = 1'b1;
      send(32'h7FF00093, IMM_I, 32'h000007FF, 64'h7FF, 1'b0, 1'b1, 1'b0);

      // Drain and confirm nothing is left over
      idle(1);
      n = 0;
      while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      idle(2);
      check("drain_q32_empty", 64'(q32.size()), 64'd0);
      check("drain_q64_empty", 64'(q64.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
